// File: rtl/monitor_sensores.sv
// rtl/monitor_sensores.sv - persistence-filtered sensor fault latch with alarm, blink LED and interlock
module monitor_sensores #(
  parameter int FILTER_CYCLES = 4,
  parameter int BLINK_HALF    = 25
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       v_sense,
  input  logic [2:0] sensores,
  input  logic       ack,
  output logic       alarme,
  output logic       led_alarme,
  output logic       bloqueio,
  output logic [2:0] falha
);

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    VERIFICA    = 2'd1,
    ALARME      = 2'd2,
    RECONHECIDO = 2'd3
  } state_t;

  localparam logic [7:0]  CNT_LAST   = 8'(FILTER_CYCLES - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;
  logic [2:0]  falha_q, falha_d;
  logic        alarme_q, alarme_d;
  logic        led_q, led_d;
  logic        bloqueio_q, bloqueio_d;

  // State and datapath registers; reset wins over every other input
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= NORMAL;
      cnt_q       <= 8'd0;
      blink_cnt_q <= 16'd0;
      blink_q     <= 1'b0;
      falha_q     <= 3'b000;
      alarme_q    <= 1'b0;
      led_q       <= 1'b0;
      bloqueio_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      falha_q     <= falha_d;
      alarme_q    <= alarme_d;
      led_q       <= led_d;
      bloqueio_q  <= bloqueio_d;
    end
  end

  // Next-state, filter, blink and sticky-record logic; outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blink_cnt_d = 16'd0;
    blink_d     = blink_q;
    falha_d     = falha_q;

    case (state_q)
      NORMAL: begin
        if (v_sense) begin
          state_d = VERIFICA;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      VERIFICA: begin
        if (!v_sense) begin
          state_d = NORMAL;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ALARME;
          cnt_d       = 8'd0;
          falha_d     = ~sensores;
          blink_cnt_d = 16'd0;
          blink_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ALARME: begin
        falha_d = falha_q | ~sensores;
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = 16'd0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
        // Without ack the fault stays latched even if v_sense drops
        if (ack) begin
          state_d = v_sense ? RECONHECIDO : NORMAL;
        end
      end
      RECONHECIDO: begin
        falha_d = falha_q | ~sensores;
        if (!v_sense) begin
          state_d = NORMAL;
        end
      end
      default: begin
        state_d = NORMAL;
      end
    endcase

    // Blink counter only runs while in ALARME
    if (state_d != ALARME) begin
      blink_cnt_d = 16'd0;
    end
    // Record is wiped whenever the monitor returns to NORMAL
    if (state_d == NORMAL) begin
      falha_d = 3'b000;
      cnt_d   = 8'd0;
    end

    alarme_d   = (state_d == ALARME);
    bloqueio_d = (state_d == ALARME) || (state_d == RECONHECIDO);
    led_d      = (state_d == ALARME) ? blink_d : (state_d == RECONHECIDO);
  end

  assign alarme     = alarme_q;
  assign led_alarme = led_q;
  assign bloqueio   = bloqueio_q;
  assign falha      = falha_q;

endmodule

// File: tb/tb_monitor_sensores.sv
// tb/tb_monitor_sensores.sv - directed self-checking bench for monitor_sensores
module tb_monitor_sensores;

  logic       clock;
  logic       reset_n;
  logic       v_sense;
  logic [2:0] sensores;
  logic       ack;
  logic       alarme;
  logic       led_alarme;
  logic       bloqueio;
  logic [2:0] falha;

  int n_checks;
  int n_fail;

  monitor_sensores #(
    .FILTER_CYCLES(4),
    .BLINK_HALF   (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .v_sense   (v_sense),
    .sensores  (sensores),
    .ack       (ack),
    .alarme    (alarme),
    .led_alarme(led_alarme),
    .bloqueio  (bloqueio),
    .falha     (falha)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {alarme, led_alarme, bloqueio, falha};
  endfunction

  logic [8:0] blink_pat;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    blink_pat = 9'b111000111;
    reset_n   = 1'b0;
    v_sense   = 1'b1;
    ack       = 1'b1;
    sensores  = 3'b111;

    // Reset overrides v_sense and ack
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outs", 32'(outs()), 32'h0);
    end

    // Release: confirm takes 4 edges counting the first sampled high
    reset_n  = 1'b1;
    ack      = 1'b0;
    sensores = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("confirm_alarme", 32'(alarme), (i == 3) ? 32'd1 : 32'd0);
    end
    check("confirm_falha", 32'(falha), 32'b001);
    check("confirm_bloqueio", 32'(bloqueio), 32'd1);

    // Ack while fault already gone -> straight to NORMAL
    ack     = 1'b1;
    v_sense = 1'b0;
    step();
    check("ack_clear_outs", 32'(outs()), 32'h0);
    ack = 1'b0;

    // Glitch of 3 cycles is rejected
    v_sense = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("glitch_alarme_blq", 32'({alarme, bloqueio}), 32'h0);
    end
    v_sense = 1'b0;
    step();
    check("glitch_end_outs", 32'(outs()), 32'h0);

    // Full 4-cycle fault with sensores=110
    v_sense  = 1'b1;
    sensores = 3'b110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("trip_alarme", 32'(alarme), (i == 3) ? 32'd1 : 32'd0);
    end
    check("trip_falha", 32'(falha), 32'b001);

    // Blink pattern 1,1,1,0,0,0,1,1,1 starting at the entry edge
    check("blink_0", 32'(led_alarme), 32'(blink_pat[8]));
    for (int i = 1; i < 9; i++) begin
      step();
      check("blink", 32'(led_alarme), 32'(blink_pat[8 - i]));
    end

    // Latched: v_sense low does not release the alarm
    v_sense = 1'b0;
    step();
    check("latched_alarme", 32'(alarme), 32'd1);

    // Sticky record accumulation
    sensores = 3'b010;
    step();
    check("sticky_101", 32'(falha), 32'b101);
    sensores = 3'b111;
    step();
    check("sticky_hold", 32'(falha), 32'b101);

    // Ack with fault present -> RECONHECIDO
    v_sense = 1'b1;
    ack     = 1'b1;
    step();
    check("ackf_outs", 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 3'b101}));
    step();
    check("ackf_steady", 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 3'b101}));
    ack     = 1'b0;
    v_sense = 1'b0;
    step();
    check("reco_clear_outs", 32'(outs()), 32'h0);

    // Mid-alarm reset, then full re-confirm
    v_sense  = 1'b1;
    sensores = 3'b011;
    for (int i = 0; i < 4; i++) step();
    check("trip2_outs", 32'(outs()), 32'({1'b1, 1'b1, 1'b1, 3'b100}));
    reset_n = 1'b0;
    step();
    check("midreset_outs", 32'(outs()), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("reconfirm_alarme", 32'(alarme), (i == 3) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_sensores.md
# monitor_sensores

Supervisory stage directly downstream of the tank sensor combiner. It consumes the combined sensor-fault flag `v_sense` and the three raw sensor lines (SP, SR, SN). It rejects short fault glitches with a persistence filter, then latches a confirmed fault. While the fault is latched it drives an operator alarm LED and an actuator interlock, and it records which sensors dropped out until the operator acknowledges the alarm and the fault clears.

## Interface
- `FILTER_CYCLES`, default 4: number of consecutive sampled-high cycles of `v_sense` needed to confirm a fault. Legal range is 2 to 255.
- `BLINK_HALF`, default 25: alarm LED half-period in clock cycles. Legal range is 1 to 65535.
- `clock`, input, 1 bit: system clock. All logic is on the rising edge.
- `reset_n`, input, 1 bit: one clock; reset is synchronous and active-low. It has priority over every other input.
- `v_sense`, input, 1 bit: sensor-fault flag from the upstream stage. 1 means at least one sensor is inactive.
- `sensores`, input, 3 bits: raw sensor states. [2]=SP, [1]=SR, [0]=SN. 1 means the sensor is active.
- `ack`, input, 1 bit: operator acknowledge, level-sampled.
- `alarme`, output, 1 bit: 1 only while a confirmed fault is unacknowledged.
- `led_alarme`, output, 1 bit: blinks while unacknowledged, held steady at 1 after acknowledge.
- `bloqueio`, output, 1 bit: actuator interlock. 1 whenever a confirmed fault is latched, acknowledged or not.
- `falha`, output, 3 bits: sticky record of sensors seen inactive since the fault was confirmed. Bit order matches `sensores`.

## Operation
- FSM states: NORMAL, VERIFICA, ALARME, RECONHECIDO.
- **NORMAL**
  - `v_sense`=1 → VERIFICA with `cnt`=1.
  - Otherwise stay in NORMAL with `cnt`=0.
- **VERIFICA**
  - `v_sense`=0 → NORMAL with `cnt`=0. Filter progress is discarded.
  - `v_sense`=1 and `cnt`=`FILTER_CYCLES`-1 → ALARME. Load `falha` ← `~sensores` and set the blink counter to 0.
  - `v_sense`=1 otherwise → `cnt`+1.
- **ALARME**
  - `falha` ← `falha | ~sensores` every cycle.
  - `ack`=1 and `v_sense`=1 → RECONHECIDO.
  - `ack`=1 and `v_sense`=0 → NORMAL.
  - `ack`=0 → stay in ALARME, even if `v_sense` returns to 0. The fault stays latched.
- **RECONHECIDO**
  - `falha` keeps accumulating.
  - `v_sense`=0 → NORMAL.
  - `ack` is ignored in this state.
- On entry to NORMAL, `falha` ← 0.
- Output decode (all outputs registered):
  - `alarme` = (state == ALARME).
  - `bloqueio` = (state ∈ {ALARME, RECONHECIDO}).
  - `led_alarme` = 0 in NORMAL and VERIFICA, the blink value in ALARME, and 1 in RECONHECIDO.
- Blink generator:
  - 16-bit counter, active only in ALARME.
  - Counts 0 to `BLINK_HALF`-1, then wraps. At each wrap, the blink value toggles.
  - On entry to ALARME, the blink value is 1 and the counter is 0. The LED is therefore 1 for `BLINK_HALF` cycles, then 0 for `BLINK_HALF` cycles, repeating.
  - The counter is held at 0 outside ALARME.
- Width rules:
  - `cnt` is 8 bits and never exceeds `FILTER_CYCLES`-1.
  - The blink counter never exceeds `BLINK_HALF`-1.
  - No overflow is reachable within the legal parameter ranges.

## Timing
- Reset: `reset_n`=0 sampled at an edge forces the following on that edge, regardless of `v_sense` and `ack`:
  - state NORMAL;
  - `cnt` and the blink counter cleared to 0;
  - `alarme`, `led_alarme`, `bloqueio` = 0;
  - `falha` = 000.
- Confirm latency: if `v_sense` is first sampled high at edge k and stays high, `alarme`, `bloqueio` and `led_alarme` rise after edge k+`FILTER_CYCLES`-1.
- Glitch rejection: a high pulse of fewer than `FILTER_CYCLES` sampled cycles never asserts any output.
- Acknowledge: `ack` sampled at edge j while in ALARME makes `alarme` fall after edge j.
  - If `v_sense`=1 at edge j, `led_alarme` becomes steady 1.
  - If `v_sense`=0 at edge j, all outputs clear after edge j.
- Clear: in RECONHECIDO, `v_sense`=0 sampled at edge j clears all outputs after edge j.
- Simultaneous `ack` and `v_sense` change at the same edge: the sampled values of both decide the transition as defined above. There is no priority between them beyond that.
- Reset mid-alarm or mid-filter: outputs clear at that edge. After release, a fault must be re-confirmed over the full `FILTER_CYCLES`.

## Test plan
- **Reset override:** `reset_n`=0 for 3 cycles with `v_sense`=1, `ack`=1 → all outputs 0 throughout. After release, `alarme`=1 exactly 4 edges after the first sampled `v_sense`=1 (F=4).
- **Glitch filter:** F=4, `v_sense` high for 3 cycles then low → `alarme` and `bloqueio` never assert. Then hold `v_sense` high for 4 cycles with `sensores`=110 → `alarme`=1 and `falha`=001 after the 4th edge.
- **Blink:** `BLINK_HALF`=3, in ALARME with no `ack` → `led_alarme` samples 1,1,1,0,0,0,1,1,1. Setting `v_sense`=0 keeps `alarme`=1 (latched).
- **Sticky record:** after tripping with `sensores`=110, drive `sensores`=010 → `falha`=101. Then drive `sensores`=111 → `falha` stays 101.
- **Acknowledge with fault present:** `ack`=1 while `v_sense`=1 → `alarme`=0, `led_alarme`=1 steady, `bloqueio`=1. Then `v_sense`=0 → `falha`=000 and all outputs 0 on the next edge.
- **Acknowledge after clear and mid-alarm reset:** `ack` in ALARME with `v_sense`=0 → NORMAL in one edge with all outputs 0. Separately, `reset_n`=0 mid-ALARME → all outputs 0 at that edge.
